// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

  // Byte lanes per memory word; lane logic is built around a 32-bit word.
  localparam int LANES = 4;

  // Request size encodings.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0]              i_word,    // word read from memory
  input  logic [31:0]              i_wdata,   // right-justified store data
  input  logic [$clog2(LANES)-1:0] i_off,     // byte offset within the word
  input  logic [1:0]               i_size,
  input  logic                     i_signed,
  output logic [31:0]              o_rdata,   // extended load result
  output logic [31:0]              o_merged   // old word with addressed lane replaced
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it to a full word; reserved size reads as a word.
  always_comb begin
    w_byte  = i_word[{i_off, 3'b000} +: 8];
    w_half  = i_word[{i_off[1], 4'b0000} +: 16];
    o_rdata = i_word;
    case (i_size)
      SZ_BYTE: o_rdata = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      SZ_HALF: o_rdata = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: o_rdata = i_word;
    endcase
  end

  // Overwrite only the addressed lane with the low bits of the store data.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_HALF: o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a single-port word memory; sub-word stores use read-modify-write.
// Latency: load 2 cycles, word store 1, sub-word store 3 (accept edge to rsp_valid); trap 0 with LSU_MISALIGN_TRAP_EN.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata   // valid in RD_WAIT, one cycle after the mem_read pulse
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W+1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_err;
  logic [1:0]        w_size_n;
  logic [ADDR_W+1:0] w_addr_n;
  logic [DATA_W-1:0] w_loaded;
  logic [DATA_W-1:0] w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned or reserved-size requests are answered with an error and never touch memory.
  always_comb begin
    w_size_n = req_size;
    w_addr_n = req_addr;
    w_err    = (req_size == SZ_RSVD) ||
               ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end
`else
  // Without trapping, low address bits are forced aligned and the reserved size acts as a word.
  always_comb begin
    w_err    = 1'b0;
    w_size_n = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    w_addr_n = req_addr;
    if (w_size_n == SZ_HALF) w_addr_n[0]   = 1'b0;
    if (w_size_n == SZ_WORD) w_addr_n[1:0] = 2'b00;
  end
`endif

  lsu_lane_align u_lane (
    .i_word   (mem_rdata),
    .i_wdata  (r_wdata),
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_rdata  (w_loaded),
    .o_merged (w_merged)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state: loads and sub-word stores read first, word stores write directly.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_err)                                   w_next_state = RESP;
          else if (req_write && (w_size_n == SZ_WORD)) w_next_state = WR_ISSUE;
          else                                         w_next_state = RD_ISSUE;
        end
      end
      RD_ISSUE: w_next_state = RD_WAIT;
      RD_WAIT:  w_next_state = r_write ? WR_ISSUE : RESP;
      WR_ISSUE: w_next_state = RESP;
      RESP:     if (rsp_ready) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded straight from the state register.
  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE:     req_ready = 1'b1;
      RD_ISSUE: mem_read  = 1'b1;
      WR_ISSUE: mem_write = 1'b1;
      RESP:     rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request latch plus response/write-data registers; memory data is consumed only in RD_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_size      <= w_size_n;
            r_signed    <= req_signed;
            r_addr      <= w_addr_n;
            r_wdata     <= req_wdata;
            r_mem_wdata <= req_write ? req_wdata : '0;
            r_rdata     <= '0;
            r_err       <= w_err;
          end
        end
        RD_WAIT: begin
          if (r_write) r_mem_wdata <= w_merged;
          else         r_rdata     <= w_loaded;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mem_addr  = r_addr[ADDR_W+1:2];
  assign mem_wdata = r_mem_wdata;

endmodule
